adder_carry_seq: RTL and testbench
==================================

# adder_carry_seq

Multi-cycle, parametrised adder/subtractor. It takes two W-bit operands in one cycle, then processes them N bits per clock through one N-bit carry-chain slice, with the carry held in a register between slices. It returns the W-bit sum, the carry-out and the signed overflow, with a start/ready/done_tick handshake. It replaces single-cycle wide adders in datapaths where a wide combinational carry chain would limit timing.

## Interface
- W, 16: operand and result width. Must be a non-zero multiple of N.
- N, 4: slice width, i.e. bits processed per cycle.
- K, W/N: slice count, derived and not overridden. The counter is max(1, clog2(K)) bits wide.

- clk, input, 1: single clock. All state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request an operation. Sampled only while ready=1.
- sub, input, 1: operation select. 0 = a+b, 1 = a−b. Sampled with start.
- a, input, W: operand A. Sampled with start.
- b, input, W: operand B. Sampled with start.
- ready, output, 1: idle and able to accept start.
- done_tick, output, 1: one-cycle pulse. Results are valid in this cycle.
- sum, output, W: result, registered.
- cout, output, 1: carry-out of the MSB. For sub, 1 means no borrow (a ≥ b unsigned).
- ovf, output, 1: two's-complement signed overflow.

## Operation
- The FSM has three states: IDLE, OP and DONE.
  - IDLE: ready=1.
  - start=1 in IDLE: latch a, latch b⊕{W{sub}}, latch sub, set the carry register to sub, clear the slice counter, go to OP.
  - OP: each cycle, compute {c, s} = a_reg[N−1:0] + b_reg[N−1:0] + carry. Store c in the carry register. Shift a_reg and b_reg right by N. Shift s into the top of the internal sum shift register. Increment the counter.
  - OP, after the cycle with counter = K−1: load sum, cout and ovf, go to DONE.
  - DONE: done_tick=1 for one cycle, then return to IDLE.
- ovf = (A_msb == B′_msb) && (sum_msb ≠ A_msb), where B′ is the latched, possibly inverted b.
- sum, cout and ovf change only on the DONE-entry edge. They hold their values until the next completion.
- start outside IDLE is ignored. Operand and sub changes after acceptance have no effect.
- Reset, including in the middle of an operation:
  - state = IDLE, counter = 0, carry = 0, operand and sum shift registers = 0.
  - sum = 0, cout = 0, ovf = 0, done_tick = 0, ready = 1.
  - An aborted operation produces no done_tick.
- All arithmetic is unsigned modulo 2^W. The per-slice adder is N+1 bits wide.

## Timing
- start accepted in cycle t.
- OP occupies cycles t+1 … t+K.
- done_tick and valid outputs in cycle t+K+1.
- ready=0 in cycles t+1 … t+K+1, ready=1 in cycle t+K+2.
- Latency: K+1 cycles from acceptance to done_tick. Throughput: one operation per K+2 cycles.
- Degenerate case W=N (K=1): done_tick at t+2.
- No combinational path from the inputs to any output. All outputs are registered or decoded from state.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE, OP, DONE);
  - the counter-width function max(1, clog2(K)).
- One sub-module: adder_carry_cin, parameter N, a combinational N-bit adder with carry-in, sum and carry-out. It is instantiated once as the slice.
- Everything else lives in adder_carry_seq: FSM, counter, shift registers, output registers.

## Test plan
All scenarios use W=16, N=4 unless stated; start is accepted at cycle 0.
- Add 0xFFFF + 0x0001: ready drops at cycle 1; done_tick at cycle 5 with sum=0x0000, cout=1, ovf=0.
- Add 0x7FFF + 0x0001: sum=0x8000, cout=0, ovf=1.
- Sub 0x0005 − 0x0007: sum=0xFFFE, cout=0, ovf=0.
- Sub 0x8000 − 0x0001: sum=0x7FFF, cout=1, ovf=1.
- Handshake:
  - start with 0x1234 + 0x1111 at cycle 0;
  - a second start with different operands at cycle 2 is ignored;
  - done_tick at cycle 5 with sum=0x2345;
  - start again at cycle 6 is accepted, with its done_tick at cycle 11.
- Reset and degenerate width:
  - reset asserted in cycle 3 of an operation: no done_tick, and all outputs 0 with ready=1 from cycle 4;
  - W=N=8, 0xFF + 0x01: done_tick at cycle 2 with sum=0x00, cout=1.

Source files
------------

// File: rtl/adder_carry_seq_pkg.sv
// rtl/adder_carry_seq_pkg.sv - shared state encoding and counter sizing for adder_carry_seq
package adder_carry_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OP   = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A single-slice adder still needs a 1-bit counter.
    function automatic int counter_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/adder_carry_seq_if.sv
// rtl/adder_carry_seq_if.sv - operand/result handshake bundle for adder_carry_seq
interface adder_carry_seq_if #(
    parameter int W = 16
);
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done_tick;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, a, b,
        input  ready, done_tick, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output ready, done_tick, sum, cout, ovf
    );
endinterface

// File: rtl/adder_carry_cin.sv
// rtl/adder_carry_cin.sv - combinational N-bit adder slice with carry-in and carry-out
module adder_carry_cin #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

// File: rtl/adder_carry_seq.sv
// rtl/adder_carry_seq.sv - multi-cycle add/sub processing N bits per clock through one carry slice
module adder_carry_seq
    import adder_carry_seq_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               reset,
    adder_carry_seq_if.slave   bus
);
    localparam int K  = W / N;
    localparam int CW = counter_width(K);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_sh;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;

    logic [N-1:0]  slice_s;
    logic          slice_c;
    logic [W-1:0]  sum_next;

    adder_carry_cin #(.N(N)) slice (
        .a    (a_reg[N-1:0]),
        .b    (b_reg[N-1:0]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_c)
    );

    // New slice enters at the top; after K shifts the full sum is aligned.
    assign sum_next = (sum_sh >> N) | (W'(slice_s) << (W - N));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            sum_sh <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b ^ {W{bus.sub}};
                        carry <= bus.sub;
                        cnt   <= '0;
                        state <= ST_OP;
                    end
                end
                ST_OP: begin
                    carry  <= slice_c;
                    a_reg  <= a_reg >> N;
                    b_reg  <= b_reg >> N;
                    sum_sh <= sum_next;
                    cnt    <= cnt + CW'(1);
                    // On the last slice the low bits of a_reg/b_reg hold the operand MSBs.
                    if (cnt == CW'(K - 1)) begin
                        sum_q  <= sum_next;
                        cout_q <= slice_c;
                        ovf_q  <= (a_reg[N-1] == b_reg[N-1]) && (slice_s[N-1] != a_reg[N-1]);
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready     = (state == ST_IDLE);
    assign bus.done_tick = (state == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_adder_carry_seq.sv
// tb/tb_adder_carry_seq.sv - self-checking bench for adder_carry_seq (W=16/N=4 and W=N=8)
module tb_adder_carry_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    adder_carry_seq_if #(.W(16)) i16 ();
    adder_carry_seq_if #(.W(8))  i8 ();

    adder_carry_seq #(.W(16), .N(4)) dut16 (.clk(clk), .reset(reset), .bus(i16));
    adder_carry_seq #(.W(8),  .N(8)) dut8  (.clk(clk), .reset(reset), .bus(i8));

    typedef struct {
        bit          sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_sum;
        bit          exp_cout;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input bit s, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] es, output bit ec, output bit eo);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int r;
        if (s) begin
            es = 16'(ua - ub);
            ec = (ua >= ub);
            r  = sa - sb;
        end else begin
            es = 16'(ua + ub);
            ec = ((ua + ub) > 65535);
            r  = sa + sb;
        end
        eo = (r > 32767) || (r < -32768);
    endfunction

    // Starts in the current cycle (cycle 0); returns in cycle lat+1 with ready expected high.
    task automatic run16(input bit s, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] rs, output bit rc, output bit ro,
                         output int lat, output bit rdy1);
        i16.start = 1'b1;
        i16.sub   = s;
        i16.a     = a;
        i16.b     = b;
        tick();
        rdy1 = i16.ready;
        lat  = -1;
        for (int c = 1; c <= 20; c++) begin
            if (i16.done_tick) begin
                lat = c;
                break;
            end
            i16.start = 1'($urandom);
            i16.sub   = 1'($urandom);
            i16.a     = 16'($urandom);
            i16.b     = 16'($urandom);
            tick();
        end
        i16.start = 1'b0;
        rs = i16.sum;
        rc = i16.cout;
        ro = i16.ovf;
        tick();
    endtask

    initial begin
        logic [15:0] rs, es;
        bit          rc, ro, ec, eo, rdy1;
        int          lat;
        int          dcount;

        vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

        i16.start = 1'b0; i16.sub = 1'b0; i16.a = '0; i16.b = '0;
        i8.start  = 1'b0; i8.sub  = 1'b0; i8.a  = '0; i8.b  = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        check("reset ready", i16.ready, 1);
        check("reset done_tick", i16.done_tick, 0);
        check("reset sum", i16.sum, 0);
        check("reset cout", i16.cout, 0);
        check("reset ovf", i16.ovf, 0);
        check("reset ready w8", i8.ready, 1);

        foreach (vecs[i]) begin
            run16(vecs[i].sub, vecs[i].a, vecs[i].b, rs, rc, ro, lat, rdy1);
            check($sformatf("vec%0d ready at cycle 1", i), rdy1, 0);
            check($sformatf("vec%0d done latency", i), lat, 5);
            check($sformatf("vec%0d sum", i), rs, vecs[i].exp_sum);
            check($sformatf("vec%0d cout", i), rc, vecs[i].exp_cout);
            check($sformatf("vec%0d ovf", i), ro, vecs[i].exp_ovf);
            check($sformatf("vec%0d ready after done", i), i16.ready, 1);
        end

        // Handshake: second start mid-operation ignored, back-to-back restart at cycle 6.
        i16.start = 1'b1; i16.sub = 1'b0; i16.a = 16'h1234; i16.b = 16'h1111;
        tick();
        i16.start = 1'b0;
        tick();
        i16.start = 1'b1; i16.a = 16'hFFFF; i16.b = 16'hFFFF;
        tick();
        i16.start = 1'b0;
        check("hs sum held during op", i16.sum, 16'h0000);
        tick();
        check("hs no done at cycle 4", i16.done_tick, 0);
        tick();
        check("hs done at cycle 5", i16.done_tick, 1);
        check("hs sum", i16.sum, 16'h2345);
        tick();
        check("hs ready at cycle 6", i16.ready, 1);
        i16.start = 1'b1; i16.a = 16'h0100; i16.b = 16'h0200;
        tick();
        i16.start = 1'b0;
        repeat (3) tick();
        check("hs2 no done at cycle 10", i16.done_tick, 0);
        tick();
        check("hs2 done at cycle 11", i16.done_tick, 1);
        check("hs2 sum", i16.sum, 16'h0300);
        tick();

        // Reset in cycle 3 of an operation aborts it without a done_tick.
        i16.start = 1'b1; i16.a = 16'h1111; i16.b = 16'h2222;
        tick();
        i16.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst ready", i16.ready, 1);
        check("rst done_tick", i16.done_tick, 0);
        check("rst sum", i16.sum, 0);
        check("rst cout", i16.cout, 0);
        check("rst ovf", i16.ovf, 0);
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            if (i16.done_tick) dcount++;
            tick();
        end
        check("rst no done_tick after abort", dcount, 0);

        // Degenerate width: W = N = 8, single slice.
        i8.start = 1'b1; i8.sub = 1'b0; i8.a = 8'hFF; i8.b = 8'h01;
        tick();
        i8.start = 1'b0; i8.a = 8'h55; i8.b = 8'h66;
        check("w8 ready at cycle 1", i8.ready, 0);
        check("w8 no done at cycle 1", i8.done_tick, 0);
        tick();
        check("w8 done at cycle 2", i8.done_tick, 1);
        check("w8 sum", i8.sum, 8'h00);
        check("w8 cout", i8.cout, 1);
        check("w8 ovf", i8.ovf, 0);
        tick();
        check("w8 ready at cycle 3", i8.ready, 1);

        // Randomised operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] ra, rb;
            bit          rsub;
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rsub = 1'($urandom);
            if (n % 8 == 0) ra = 16'h8000;
            if (n % 8 == 1) rb = 16'h7FFF;
            model(rsub, ra, rb, es, ec, eo);
            run16(rsub, ra, rb, rs, rc, ro, lat, rdy1);
            check($sformatf("rnd%0d latency", n), lat, 5);
            check($sformatf("rnd%0d sum a=%h b=%h sub=%0d", n, ra, rb, rsub), rs, es);
            check($sformatf("rnd%0d cout", n), rc, ec);
            check($sformatf("rnd%0d ovf", n), ro, eo);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
